// File: rtl/lnrv_exu_flush_ctrl_pkg.sv
// Shared definitions for the EXU flush controller: one-hot grant sources,
// FSM states and the drain counter width.
package lnrv_exu_flush_ctrl_pkg;

    localparam int unsigned FLUSH_DRAIN_CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        FLUSH_SRC_NONE = 3'b000,
        FLUSH_SRC_BRCH = 3'b001,
        FLUSH_SRC_EXCP = 3'b010,
        FLUSH_SRC_DBG  = 3'b100
    } flush_src_e;

    typedef enum logic [1:0] {
        FLUSH_ST_IDLE,
        FLUSH_ST_CALC,
        FLUSH_ST_REQ,
        FLUSH_ST_DRAIN
    } flush_st_e;

endpackage

// File: rtl/lnrv_prio_arb3.sv
// Combinational three-way fixed-priority arbiter with a one-hot grant;
// req[2] has the highest priority and req[0] the lowest.
module lnrv_prio_arb3 (
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[2]) begin
            gnt[2] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end else if (req[0]) begin
            gnt[0] = 1'b1;
        end
    end

endmodule

// File: rtl/lnrv_exu_flush_ctrl.sv
// EXU flush controller: arbitrates branch/trap/debug flushes, registers the
// redirect target, handshakes with the IFU and blocks issue until drained.
module lnrv_exu_flush_ctrl
    import lnrv_exu_flush_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                brch_flush_req,
    input  logic [PC_WIDTH-1:0] brch_flush_pc_op1,
    input  logic [PC_WIDTH-1:0] brch_flush_pc_op2,
    output logic                brch_flush_ack,
    input  logic                excp_flush_req,
    input  logic [PC_WIDTH-1:0] excp_flush_pc,
    output logic                excp_flush_ack,
    input  logic                dbg_flush_req,
    input  logic [PC_WIDTH-1:0] dbg_flush_pc,
    output logic                dbg_flush_ack,
    output logic                ifu_flush_req,
    output logic [PC_WIDTH-1:0] ifu_flush_pc,
    input  logic                ifu_flush_ack,
    output logic                issue_block
);

    flush_st_e                        state_q, state_d;
    flush_src_e                       grant_q, grant_d;
    logic [PC_WIDTH-1:0]              pc_q, pc_d;
    logic [FLUSH_DRAIN_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]              brch_target;
    logic [PC_WIDTH-1:0]              sel_target;
    logic [2:0]                       req_vec;
    logic [2:0]                       gnt_vec;
    logic                             any_req;

    assign req_vec = {dbg_flush_req, excp_flush_req, brch_flush_req};
    assign any_req = |req_vec;

    lnrv_prio_arb3 u_arb (
        .req (req_vec),
        .gnt (gnt_vec)
    );

    // Carry out of the adder is intentionally dropped (wraps modulo 2^PC_WIDTH).
    assign brch_target = brch_flush_pc_op1 + brch_flush_pc_op2;

    always_comb begin
        sel_target = '0;
        unique case (grant_q)
            FLUSH_SRC_BRCH: sel_target = brch_target;
            FLUSH_SRC_EXCP: sel_target = excp_flush_pc;
            FLUSH_SRC_DBG:  sel_target = dbg_flush_pc;
            default:        sel_target = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FLUSH_ST_IDLE;
            grant_q <= FLUSH_SRC_NONE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        ifu_flush_req  = 1'b0;
        brch_flush_ack = 1'b0;
        excp_flush_ack = 1'b0;
        dbg_flush_ack  = 1'b0;

        unique case (state_q)
            FLUSH_ST_IDLE: begin
                if (any_req) begin
                    grant_d = flush_src_e'(gnt_vec);
                    state_d = FLUSH_ST_CALC;
                end
            end
            FLUSH_ST_CALC: begin
                pc_d    = {sel_target[PC_WIDTH-1:1], 1'b0};
                state_d = FLUSH_ST_REQ;
            end
            FLUSH_ST_REQ: begin
                ifu_flush_req = 1'b1;
                if (ifu_flush_ack) begin
                    {dbg_flush_ack, excp_flush_ack, brch_flush_ack} = grant_q;
                    cnt_d   = FLUSH_DRAIN_CNT_WIDTH'(DRAIN_CYCLES);
                    state_d = FLUSH_ST_DRAIN;
                end
            end
            FLUSH_ST_DRAIN: begin
                cnt_d = cnt_q - FLUSH_DRAIN_CNT_WIDTH'(1);
                if (cnt_q == FLUSH_DRAIN_CNT_WIDTH'(1)) begin
                    grant_d = FLUSH_SRC_NONE;
                    state_d = FLUSH_ST_IDLE;
                end
            end
            default: state_d = FLUSH_ST_IDLE;
        endcase
    end

    assign ifu_flush_pc = pc_q;
    // Gated by rst so a held request cannot raise issue_block during reset.
    assign issue_block  = !rst && ((state_q != FLUSH_ST_IDLE) || any_req);

endmodule

// File: tb/tb_lnrv_exu_flush_ctrl.sv
// Self-checking bench for lnrv_exu_flush_ctrl: directed scenarios plus
// randomized rounds against a transaction-level timing/priority model.
module tb_lnrv_exu_flush_ctrl;

    localparam int unsigned PCW   = 32;
    localparam int unsigned DRAIN = 2;

    logic           clk;
    logic           rst;
    logic           brch_flush_req;
    logic [PCW-1:0] brch_flush_pc_op1;
    logic [PCW-1:0] brch_flush_pc_op2;
    logic           brch_flush_ack;
    logic           excp_flush_req;
    logic [PCW-1:0] excp_flush_pc;
    logic           excp_flush_ack;
    logic           dbg_flush_req;
    logic [PCW-1:0] dbg_flush_pc;
    logic           dbg_flush_ack;
    logic           ifu_flush_req;
    logic [PCW-1:0] ifu_flush_pc;
    logic           ifu_flush_ack;
    logic           issue_block;

    int checks   = 0;
    int failures = 0;

    lnrv_exu_flush_ctrl #(
        .PC_WIDTH     (PCW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .brch_flush_req    (brch_flush_req),
        .brch_flush_pc_op1 (brch_flush_pc_op1),
        .brch_flush_pc_op2 (brch_flush_pc_op2),
        .brch_flush_ack    (brch_flush_ack),
        .excp_flush_req    (excp_flush_req),
        .excp_flush_pc     (excp_flush_pc),
        .excp_flush_ack    (excp_flush_ack),
        .dbg_flush_req     (dbg_flush_req),
        .dbg_flush_pc      (dbg_flush_pc),
        .dbg_flush_ack     (dbg_flush_ack),
        .ifu_flush_req     (ifu_flush_req),
        .ifu_flush_pc      (ifu_flush_pc),
        .ifu_flush_ack     (ifu_flush_ack),
        .issue_block       (issue_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full flush round from its first IDLE cycle through the last DRAIN
    // cycle. Winner and target come from the requests held at round start;
    // timing is IDLE, CALC, (ifu_wait+1) REQ cycles, then DRAIN cycles.
    task automatic do_round(input int ifu_wait, input bit late_excp, input bit spurious);
        logic [2:0]     win;
        logic [PCW-1:0] exp_pc;
        int             n;
        bit             in_req;
        bit             ack_cyc;
        if (dbg_flush_req) begin
            win = 3'b100; exp_pc = dbg_flush_pc;
        end else if (excp_flush_req) begin
            win = 3'b010; exp_pc = excp_flush_pc;
        end else begin
            win = 3'b001; exp_pc = brch_flush_pc_op1 + brch_flush_pc_op2;
        end
        exp_pc[0] = 1'b0;
        n = 3 + ifu_wait + int'(DRAIN);
        for (int c = 0; c < n; c++) begin
            in_req  = (c >= 2) && (c <= 2 + ifu_wait);
            ack_cyc = (c == 2 + ifu_wait);
            if (ack_cyc)                 ifu_flush_ack = 1'b1;
            else if (in_req || !spurious) ifu_flush_ack = 1'b0;
            else                          ifu_flush_ack = 1'($urandom_range(0, 1));
            if (late_excp && c == 2 && !excp_flush_req) excp_flush_req = 1'b1;
            @(negedge clk);
            checks++;
            if (ifu_flush_req !== in_req) begin
                failures++;
                $display("FAIL round_ifu_req c=%0d: got %b exp %b", c, ifu_flush_req, in_req);
            end
            checks++;
            if (issue_block !== 1'b1) begin
                failures++;
                $display("FAIL round_issue_block c=%0d: got %b exp 1", c, issue_block);
            end
            checks++;
            if ({dbg_flush_ack, excp_flush_ack, brch_flush_ack} !== (ack_cyc ? win : 3'b000)) begin
                failures++;
                $display("FAIL round_acks c=%0d: got %b exp %b", c,
                         {dbg_flush_ack, excp_flush_ack, brch_flush_ack}, ack_cyc ? win : 3'b000);
            end
            if (in_req) begin
                checks++;
                if (ifu_flush_pc !== exp_pc) begin
                    failures++;
                    $display("FAIL round_pc c=%0d: got %h exp %h", c, ifu_flush_pc, exp_pc);
                end
            end
            @(posedge clk); #1;
            if (ack_cyc) begin
                if (win[2]) dbg_flush_req  = 1'b0;
                if (win[1]) excp_flush_req = 1'b0;
                if (win[0]) brch_flush_req = 1'b0;
            end
        end
        ifu_flush_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        brch_flush_req = 1'b0; excp_flush_req = 1'b0;
        dbg_flush_req = 1'b1;
        brch_flush_pc_op1 = '0; brch_flush_pc_op2 = '0;
        excp_flush_pc = '0; dbg_flush_pc = 32'h0000_0800;
        ifu_flush_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifu_flush_req, issue_block, dbg_flush_ack, excp_flush_ack, brch_flush_ack} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b exp 00000",
                     {ifu_flush_req, issue_block, dbg_flush_ack, excp_flush_ack, brch_flush_ack});
        end
        checks++;
        if (ifu_flush_pc !== '0) begin
            failures++;
            $display("FAIL reset_pc: got %h exp 0", ifu_flush_pc);
        end
        @(posedge clk); #1;
        dbg_flush_req = 1'b0;
        ifu_flush_ack = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifu_flush_req, issue_block, ifu_flush_pc} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: got req=%b blk=%b pc=%h exp all 0",
                     ifu_flush_req, issue_block, ifu_flush_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_branch_stall();
        brch_flush_pc_op1 = 32'h8000_0100;
        brch_flush_pc_op2 = 32'hFFFF_FFF8;
        brch_flush_req    = 1'b1;
        do_round(2, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({ifu_flush_req, issue_block, brch_flush_ack} !== 3'b000) begin
            failures++;
            $display("FAIL branch_stall_after: got %b exp 000", {ifu_flush_req, issue_block, brch_flush_ack});
        end
        checks++;
        if (ifu_flush_pc !== 32'h8000_00F8) begin
            failures++;
            $display("FAIL branch_stall_pc: got %h exp 800000f8", ifu_flush_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        brch_flush_pc_op1 = 32'hFFFF_FFFF;
        brch_flush_pc_op2 = 32'h0000_0003;
        brch_flush_req    = 1'b1;
        do_round(0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ifu_flush_pc !== 32'h0000_0002) begin
            failures++;
            $display("FAIL wrap_pc: got %h exp 00000002", ifu_flush_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        dbg_flush_pc      = 32'h0000_0800;
        excp_flush_pc     = 32'h8000_0040;
        brch_flush_pc_op1 = 32'h0000_1000;
        brch_flush_pc_op2 = 32'h0000_0020;
        {dbg_flush_req, excp_flush_req, brch_flush_req} = 3'b111;
        do_round(0, 1'b0, 1'b0);
        checks++;
        if ({dbg_flush_req, excp_flush_req, brch_flush_req} !== 3'b011) begin
            failures++;
            $display("FAIL simul_order_1: pending %b exp 011", {dbg_flush_req, excp_flush_req, brch_flush_req});
        end
        do_round(1, 1'b0, 1'b0);
        do_round(0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({ifu_flush_req, issue_block} !== 2'b00) begin
            failures++;
            $display("FAIL simul_done: got %b exp 00", {ifu_flush_req, issue_block});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_late_excp();
        brch_flush_pc_op1 = 32'h0000_2000;
        brch_flush_pc_op2 = 32'h0000_0010;
        excp_flush_pc     = 32'h8000_0041;
        brch_flush_req    = 1'b1;
        do_round(2, 1'b1, 1'b0);
        checks++;
        if ({excp_flush_req, brch_flush_req} !== 2'b10) begin
            failures++;
            $display("FAIL late_excp_pending: got %b exp 10", {excp_flush_req, brch_flush_req});
        end
        do_round(0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (issue_block !== 1'b0) begin
            failures++;
            $display("FAIL late_excp_done: got %b exp 0", issue_block);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_req();
        brch_flush_pc_op1 = 32'h0000_4000;
        brch_flush_pc_op2 = 32'h0000_0104;
        brch_flush_req    = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ifu_flush_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_req_setup: got %b exp 1", ifu_flush_req);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({ifu_flush_req, issue_block, dbg_flush_ack, excp_flush_ack, brch_flush_ack} !== 5'b0
            || ifu_flush_pc !== '0) begin
            failures++;
            $display("FAIL rst_in_req_outputs: got req=%b blk=%b acks=%b pc=%h exp all 0",
                     ifu_flush_req, issue_block, {dbg_flush_ack, excp_flush_ack, brch_flush_ack}, ifu_flush_pc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_round(1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (issue_block !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_req_done: got %b exp 0", issue_block);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 4; c++) begin
            ifu_flush_ack = 1'b1;
            @(negedge clk);
            checks++;
            if ({ifu_flush_req, issue_block, dbg_flush_ack, excp_flush_ack, brch_flush_ack} !== 5'b0) begin
                failures++;
                $display("FAIL spurious_idle c=%0d: got %b exp 00000", c,
                         {ifu_flush_req, issue_block, dbg_flush_ack, excp_flush_ack, brch_flush_ack});
            end
            @(posedge clk); #1;
        end
        ifu_flush_ack = 1'b0;
        excp_flush_pc  = 32'h0000_0100;
        excp_flush_req = 1'b1;
        do_round(1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int          gap;
        logic [2:0]  v;
        for (int r = 0; r < 40; r++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                ifu_flush_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if ({ifu_flush_req, issue_block, dbg_flush_ack, excp_flush_ack, brch_flush_ack} !== 5'b0) begin
                    failures++;
                    $display("FAIL random_idle r=%0d: got %b exp 00000", r,
                             {ifu_flush_req, issue_block, dbg_flush_ack, excp_flush_ack, brch_flush_ack});
                end
                @(posedge clk); #1;
            end
            ifu_flush_ack     = 1'b0;
            brch_flush_pc_op1 = $urandom;
            brch_flush_pc_op2 = $urandom;
            excp_flush_pc     = $urandom;
            dbg_flush_pc      = $urandom;
            v = 3'($urandom_range(1, 7));
            {dbg_flush_req, excp_flush_req, brch_flush_req} = v;
            while (dbg_flush_req || excp_flush_req || brch_flush_req)
                do_round($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_branch_stall();
        test_wrap();
        test_simultaneous();
        test_late_excp();
        test_reset_in_req();
        test_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
